// File: rtl/elastic_pipe_pkg.sv
// rtl/elastic_pipe_pkg.sv - shared defaults and sizing helper for the elastic pipe register
package elastic_pipe_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 3;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// rtl/elastic_pipe_stage.sv - one valid/data slot of the elastic pipe with its local ready
module elastic_pipe_stage
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy_next,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             rdy
);

  logic             v_q;
  logic             v_d;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;

  assign rdy = !v_q | rdy_next;
  assign v   = v_q;
  assign d   = d_q;

  // Flush only clears valid; data is left alone, as it is whenever no word arrives.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (rdy) begin
      v_d = vin;
      if (vin) begin
        d_d = din;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// rtl/elastic_pipe_reg.sv - DEPTH-stage valid/ready pipeline register; PIPE_OCCUPANCY_EN adds the occupancy port
module elastic_pipe_reg
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0]   occupancy
`endif
);

  if (DEPTH < 1) begin : g_depth_check
    $fatal(1, "elastic_pipe_reg: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vin;
  logic [DEPTH-1:0] rdy_nxt;
  logic [DEPTH-1:0] stg_rdy;
  logic [WIDTH-1:0] din [DEPTH];
  logic [WIDTH-1:0] dat [DEPTH];
  logic             r_acc;
  logic             unused_rdy;

  // Ready seen by each stage from downstream, built from the valids alone so the
  // ready path has no self-referencing net.
  always_comb begin
    r_acc   = out_ready;
    rdy_nxt = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy_nxt[k] = r_acc;
      r_acc      = r_acc | ~vld[k];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vin[k] = in_valid;
      assign din[k] = in_data;
    end else begin : g_body
      assign vin[k] = vld[k-1];
      assign din[k] = dat[k-1];
    end

    elastic_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .vin      (vin[k]),
      .din      (din[k]),
      .rdy_next (rdy_nxt[k]),
      .v        (vld[k]),
      .d        (dat[k]),
      .rdy      (stg_rdy[k])
    );
  end

  assign in_ready   = stg_rdy[0] & !flush;
  assign out_valid  = vld[DEPTH-1];
  assign out_data   = dat[DEPTH-1];
  assign unused_rdy = ^stg_rdy;

`ifdef PIPE_OCCUPANCY_EN
  localparam int OCC_W = occ_width(DEPTH);
  logic [OCC_W-1:0] occ;

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(vld[k]);
    end
  end

  assign occupancy = occ;
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb/tb_elastic_pipe_reg.sv - self-checking bench for elastic_pipe_reg (occupancy checks under PIPE_OCCUPANCY_EN)
module tb_elastic_pipe_reg;
  import elastic_pipe_pkg::*;

  localparam int W  = 4;
  localparam int D  = 3;
  localparam int OW = occ_width(D);

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_OCCUPANCY_EN
  logic [OW-1:0] occupancy;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  elastic_pipe_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_OCCUPANCY_EN
    ,
    .occupancy (occupancy)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_occ(input string name, input int req);
`ifdef PIPE_OCCUPANCY_EN
    chk(name, 32'(occupancy), req);
`endif
  endtask

  task automatic drive(input logic f, input logic iv, input logic [W-1:0] id, input logic ordy);
    flush     = f;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: slots ordered input->output; each word moves at most one slot per
  // cycle into a free slot, the pipe accepts whenever some slot is free or the
  // output pops, and flush empties every slot.
  logic         m_v [D];
  logic [W-1:0] m_d [D];

  function automatic int m_count();
    int n = 0;
    for (int k = 0; k < D; k++) n += int'(m_v[k]);
    return n;
  endfunction

  function automatic logic m_in_ready(input logic f, input logic ordy);
    return !f && (m_count() < D || ordy);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < D; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
    end
  endtask

  task automatic m_step(input logic f, input logic iv, input logic [W-1:0] id, input logic ordy);
    logic acc;
    acc = iv && m_in_ready(f, ordy);
    if (f) begin
      for (int k = 0; k < D; k++) m_v[k] = 1'b0;
    end else begin
      if (ordy && m_v[D-1]) m_v[D-1] = 1'b0;
      for (int k = D - 1; k >= 1; k--) begin
        if (!m_v[k] && m_v[k-1]) begin
          m_v[k]   = 1'b1;
          m_d[k]   = m_d[k-1];
          m_v[k-1] = 1'b0;
        end
      end
      if (acc) begin
        m_v[0] = 1'b1;
        m_d[0] = id;
      end
    end
  endtask

  typedef struct {
    logic         f;
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_od;
    int           e_occ;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           recv;
    int           got_n;
    logic [W-1:0] got [$];
    logic         f, iv, ordy;
    logic [W-1:0] id;

    // backpressure: fill 5,6,7, stall, then drain
    tbl[0] = '{1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 4'd0, 0};
    tbl[1] = '{1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 4'd0, 1};
    tbl[2] = '{1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 4'd0, 2};
    tbl[3] = '{1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 4'd5, 3};
    tbl[4] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 3};
    tbl[5] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd5, 3};
    tbl[6] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd6, 2};
    tbl[7] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd7, 1};
    tbl[8] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 0};

    reset = 1'b0;
    drive(1'b0, 1'($urandom), W'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      in_data  = W'($urandom);
      in_valid = 1'($urandom);
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, W'($urandom), 1'b0);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, '0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk_occ("reset_occupancy", 0);
    next_cycle();

    recv = 0;
    for (int c = 0; c < 16 + D + 3; c++) begin
      drive(1'b0, c < 16, W'(c), 1'b1);
      #1;
      if (c < 16) chk("stream_in_ready", in_ready, 1'b1);
      if (out_valid) begin
        chk("stream_data", out_data, recv);
        chk("stream_latency", c, recv + D);
        recv++;
      end
      next_cycle();
    end
    chk("stream_count", recv, 16);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].f, tbl[i].iv, tbl[i].id, tbl[i].ordy);
      #1;
      chk($sformatf("bp%0d_in_ready", i), in_ready, tbl[i].e_ir);
      chk($sformatf("bp%0d_out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk($sformatf("bp%0d_out_data", i), out_data, tbl[i].e_od);
      chk_occ($sformatf("bp%0d_occupancy", i), tbl[i].e_occ);
      next_cycle();
    end

    for (int c = 0; c < 6; c++) begin
      drive(1'b0, c == 0 || c == 3, (c == 0) ? 4'd1 : 4'd2, 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("bubble_out_valid", out_valid, 1'b1);
    chk("bubble_out_data", out_data, 4'd1);
    chk("bubble_in_ready", in_ready, 1'b1);
    chk_occ("bubble_occupancy", 2);
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("bubble_first", out_data, 4'd1);
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("bubble_adjacent_valid", out_valid, 1'b1);
    chk("bubble_second", out_data, 4'd2);
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("bubble_drained", out_valid, 1'b0);
    next_cycle();

    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, W'(9 + c), 1'b0);
      next_cycle();
    end
    drive(1'b1, 1'b1, 4'd12, 1'b0);
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    chk("flush_full_out_valid", out_valid, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready_after", in_ready, 1'b1);
    chk_occ("flush_occupancy", 0);
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      drive(1'b0, 1'b0, '0, 1'b1);
      #1;
      chk("flush_no_delivery", out_valid, 1'b0);
    end
    next_cycle();

    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, W'(1 + c), 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("areset_full_valid", out_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_out_valid", out_valid, 1'b0);
    chk("areset_in_ready", in_ready, 1'b1);
    chk_occ("areset_occupancy", 0);
    next_cycle();
    reset = 1'b1;
    drive(1'b0, 1'b1, 4'd3, 1'b1);
    next_cycle();
    drive(1'b0, 1'b1, 4'd4, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b1);
    got.delete();
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) got.push_back(out_data);
      next_cycle();
    end
    got_n = got.size();
    chk("areset_recover_count", got_n, 2);
    if (got_n >= 2) begin
      chk("areset_recover_first", got[0], 4'd3);
      chk("areset_recover_second", got[1], 4'd4);
    end

    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    next_cycle();
    reset = 1'b1;
    m_reset();
    for (int c = 0; c < 1500; c++) begin
      f    = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      id   = W'($urandom);
      ordy = (c < 750) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      drive(f, iv, id, ordy);
      #1;
      chk("rand_in_ready", in_ready, m_in_ready(f, ordy));
      chk("rand_out_valid", out_valid, m_v[D-1]);
      if (m_v[D-1]) chk("rand_out_data", out_data, m_d[D-1]);
      chk_occ("rand_occupancy", m_count());
      m_step(f, iv, id, ordy);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised successor to the plain `register`: a DEPTH-stage pipeline register of WIDTH bits with a valid/ready handshake per stage and a synchronous flush.
- Each stage holds one word and stalls independently, so bubbles collapse under backpressure.
- Used to retime long datapaths between producer/consumer blocks without losing data when the consumer stalls.

Parameters:
- WIDTH, 4, data width in bits (>=1)
- DEPTH, 3, number of pipeline stages (>=1; elaboration error via $fatal if 0)

Ports:
- clk, input, 1, rising-edge clock
- reset, input, 1, asynchronous active-low reset
- flush, input, 1, synchronous clear of all stage valids
- in_valid, input, 1, upstream word valid
- in_ready, output, 1, pipe accepts word this cycle
- in_data, input, WIDTH, upstream word
- out_valid, output, 1, last stage holds a word
- out_ready, input, 1, downstream accepts word this cycle
- out_data, output, WIDTH, last stage word
- occupancy, output, $clog2(DEPTH+1), number of valid stages (only with PIPE_OCCUPANCY_EN)

Behaviour:
- Reset (reset==0, async assert, sync-safe deassert): every stage valid=0, every stage data=0. Hence out_valid=0, out_data=0, occupancy=0, in_ready=1 (once flush==0).
- Stage k (0..DEPTH-1) holds v[k], d[k]. Stage DEPTH's ready is out_ready.
- Per-stage ready: r[k] = !v[k] | r[k+1]. This is combinational, with no register in the ready path.
- Per-stage valid input: vin[0] = in_valid and vin[k] = v[k-1] for k>0.
- in_ready = r[0] & !flush.
- On each rising clk, when r[k]: v[k] <= vin[k].
  - If vin[k], also d[k] <= din[k].
  - Data is not written when vin[k]==0, which holds the last value to save toggles.
- When !r[k], stage k holds both v[k] and d[k].
- Transfer at the input when in_valid & in_ready. Transfer at the output when out_valid & out_ready.
- Latency: a word accepted at edge n appears at out_valid on the cycle after edge n+DEPTH-1 (DEPTH cycles) with no stall. Throughput is 1 word/cycle with out_ready held 1.
- Ordering: strict FIFO. No word is dropped or duplicated except by flush.
- Full: all v[k]==1 and out_ready==0 gives in_ready==0. If out_ready==1 in the same cycle, in_ready==1 (pass-through accept while full).
- Empty: out_valid==0. out_data holds the last delivered word and is don't-care to consumers.
- flush==1 at an edge:
  - all v[k] <= 0 and data registers are unchanged.
  - The input word is not accepted (in_ready==0 during flush).
  - An output transfer in the same cycle is still counted as delivered.
- Reset asserted mid-transfer: the pipe empties immediately (async). The in-flight word is lost, and the bench treats this as legal.
- No X propagation: out_valid is never X after reset, regardless of in_data.

Optional Feature:
- Macro: PIPE_OCCUPANCY_EN.
- When defined:
  - The occupancy port exists and equals the popcount of v[], updated with the registers.
  - Reset value is 0; it is 0 the cycle after flush and equals DEPTH when full.
- When undefined: the port is absent and no counting logic is generated.
- The bench guards its checks with the same macro.

Decomposition:
- Package elastic_pipe_pkg holds:
  - function occ_width(depth) returning $clog2(depth+1)
  - a parameterised-width struct-free typedef is not needed; keep only that function and a localparam default WIDTH/DEPTH.
- One natural sub-module, elastic_pipe_stage: one valid/data pair.
  - Ports: clk, reset, flush, vin, din, rdy_next, v, d, rdy.
  - Instantiated DEPTH times in a generate loop.

Test Plan:
- Reset: reset=0 with random in_data, then release → out_valid=0, out_data=0, in_ready=1 (occupancy=0).
- Streaming: WIDTH=4, DEPTH=3, out_ready=1, feed 0..15 one per cycle → out_data sequence 0..15 with each first valid exactly 3 cycles after acceptance and no gaps.
- Backpressure: fill with 5,6,7 and hold out_ready=0 → in_ready=0 and out_data=5 held. Then raise out_ready → deliver 5,6,7 in order, and in_ready=1 on the same cycle out_ready rises.
- Bubble collapse: feed 1, idle 2 cycles, feed 2, with out_ready=0 for 6 cycles → both words are stored in adjacent stages, occupancy=2, in_ready=1.
- Flush: full pipe (9,10,11) plus in_valid=1 with data 12 and flush=1 → next cycle out_valid=0, occupancy=0, and 12 is never delivered.
- Async reset mid-stream: assert reset between edges while full → out_valid drops immediately (before the next edge). After release, a stream of 3,4 passes correctly.
